// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: pointer width rule and Gray/binary
// conversion. The conversions work on a wide zero-extended vector, so any
// pointer up to GW bits can use them by casting in and truncating out.
package fifo_pkg;

  // Widest pointer the helpers support.
  localparam int unsigned GW = 32;

  // Pointers carry one extra wrap bit above the RAM address.
  function automatic int unsigned ptr_w(input int unsigned addr_w);
    return addr_w + 1;
  endfunction

  // Binary to reflected Gray code.
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  // Zero-extended upper bits contribute nothing, so the result is width-agnostic.
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = g;
    for (int i = 1; i < int'(GW); i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl.sv
// Read-side pointer and flag controller for the dual-clock FIFO.
// Holds the binary/Gray read pointers, drives the RAM read address and
// produces registered empty, almost-empty, fill level and a sticky underflow.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned AE_RST_VAL = 4
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 rinc,
  input  logic [ADDR_W:0]      rq2_wptr,
  input  logic                 ae_thresh_we,
  input  logic [ADDR_W:0]      ae_thresh,
  input  logic                 rclr_err,
  output logic [ADDR_W:0]      rd_ptr,
  output logic [ADDR_W-1:0]    raddr,
  output logic                 rempty,
  output logic                 raempty,
  output logic [ADDR_W:0]      rlevel,
  output logic                 runderflow
);

  localparam int unsigned PW = ptr_w(ADDR_W);

  // Full-occupancy value, also the ceiling for the almost-empty threshold.
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [PW-1:0] r_bin_q,  r_bin_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          rempty_q, rempty_d;
  logic          raempty_q, raempty_d;
  logic [PW-1:0] rlevel_q, rlevel_d;
  logic          runderflow_q, runderflow_d;
  logic [PW-1:0] thresh_q, thresh_d;
  logic [PW-1:0] wbin;
  logic          pop;

  // Next-state: pointer advance, flags from the post-pop pointer, error and threshold.
  always_comb begin
    pop          = rinc & ~rempty_q;
    r_bin_d      = r_bin_q + {{ADDR_W{1'b0}}, pop};
    rd_ptr_d     = PW'(bin2gray(GW'(r_bin_d)));
    wbin         = PW'(gray2bin(GW'(rq2_wptr)));
    // Pointers never drift more than DEPTH apart, so the modular difference is the level.
    rlevel_d     = wbin - r_bin_d;
    // Gray compare over the full width so a lap apart does not read as empty.
    rempty_d     = (rd_ptr_d == rq2_wptr);
    raempty_d    = (rlevel_d <= thresh_q);
    // A new underflow outranks a clear arriving in the same cycle.
    runderflow_d = (rinc & rempty_q) | (runderflow_q & ~rclr_err);
    thresh_d     = thresh_q;
    if (ae_thresh_we) begin
      thresh_d = (ae_thresh > DEPTH) ? DEPTH : ae_thresh;
    end
  end

  // State registers; reset asserts immediately and drops any pending pop.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_bin_q      <= '0;
      rd_ptr_q     <= '0;
      rempty_q     <= 1'b1;
      raempty_q    <= 1'b1;
      rlevel_q     <= '0;
      runderflow_q <= 1'b0;
      thresh_q     <= PW'(AE_RST_VAL);
    end else begin
      r_bin_q      <= r_bin_d;
      rd_ptr_q     <= rd_ptr_d;
      rempty_q     <= rempty_d;
      raempty_q    <= raempty_d;
      rlevel_q     <= rlevel_d;
      runderflow_q <= runderflow_d;
      thresh_q     <= thresh_d;
    end
  end

  assign rd_ptr     = rd_ptr_q;
  assign raddr      = r_bin_q[ADDR_W-1:0];
  assign rempty     = rempty_q;
  assign raempty    = raempty_q;
  assign rlevel     = rlevel_q;
  assign runderflow = runderflow_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl at ADDR_W=3 (depth 8), AE_RST_VAL=2.
// Write side is modelled as a running count of words; the reference model
// tracks pops and occupancy as plain integers.
module tb_fifo_rd_ctrl;

  localparam int unsigned ADDR_W = 3;
  localparam int DEPTH = 8;

  logic       rclk;
  logic       rrst_n;
  logic       rinc;
  logic [3:0] rq2_wptr;
  logic       ae_thresh_we;
  logic [3:0] ae_thresh;
  logic       rclr_err;
  logic [3:0] rd_ptr;
  logic [2:0] raddr;
  logic       rempty;
  logic       raempty;
  logic [3:0] rlevel;
  logic       runderflow;

  fifo_rd_ctrl #(.ADDR_W(ADDR_W), .AE_RST_VAL(2)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .rinc(rinc), .rq2_wptr(rq2_wptr),
    .ae_thresh_we(ae_thresh_we), .ae_thresh(ae_thresh), .rclr_err(rclr_err),
    .rd_ptr(rd_ptr), .raddr(raddr), .rempty(rempty), .raempty(raempty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int n_total = 0;
  int n_pass  = 0;

  // Write-side word count as seen (already synchronised) by the read domain.
  int w = 0;

  // Reference model: integer counts only.
  int m_rd, m_level, m_thr;
  bit m_empty, m_ae, m_uf;

  function automatic logic [3:0] gray4(input int x);
    logic [3:0] b;
    b = 4'(x % 16);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_rd = 0; m_level = 0; m_thr = 2; m_empty = 1; m_ae = 1; m_uf = 0;
  endtask

  // One clock: present write pointer, clock, advance model, settle.
  task automatic step();
    bit was_empty;
    rq2_wptr = gray4(w);
    @(posedge rclk);
    was_empty = m_empty;
    if (rinc && !was_empty) m_rd++;
    m_level = w - m_rd;
    m_ae    = (m_level <= m_thr);
    m_empty = (m_level == 0);
    m_uf    = (rinc && was_empty) || (m_uf && !rclr_err);
    if (ae_thresh_we) m_thr = (ae_thresh > DEPTH) ? DEPTH : int'(ae_thresh);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".rempty"},     rempty,     m_empty);
    chk({tag, ".raempty"},    raempty,    m_ae);
    chk({tag, ".rlevel"},     rlevel,     m_level);
    chk({tag, ".raddr"},      raddr,      m_rd % DEPTH);
    chk({tag, ".rd_ptr"},     rd_ptr,     gray4(m_rd));
    chk({tag, ".runderflow"}, runderflow, m_uf);
  endtask

  typedef struct {
    bit rinc; int w; bit twe; int thr; bit clr;
    bit e_empty; bit e_ae; int e_lvl; int e_rd; bit e_uf;
  } vec_t;

  vec_t tbl[21];

  initial begin
    logic [3:0] prev_ptr;

    //            rinc w  twe thr clr  empty ae lvl rd uf
    tbl[0]  = '{0,  5, 0,  0, 0,   0, 0, 5, 0, 0};
    tbl[1]  = '{1,  5, 0,  0, 0,   0, 0, 4, 1, 0};
    tbl[2]  = '{1,  5, 0,  0, 0,   0, 0, 3, 2, 0};
    tbl[3]  = '{1,  5, 0,  0, 0,   0, 1, 2, 3, 0};
    tbl[4]  = '{1,  5, 0,  0, 0,   0, 1, 1, 4, 0};
    tbl[5]  = '{1,  5, 0,  0, 0,   1, 1, 0, 5, 0};
    tbl[6]  = '{1,  5, 0,  0, 0,   1, 1, 0, 5, 1};
    tbl[7]  = '{1,  5, 0,  0, 0,   1, 1, 0, 5, 1};
    tbl[8]  = '{1,  5, 0,  0, 0,   1, 1, 0, 5, 1};
    tbl[9]  = '{0,  5, 0,  0, 1,   1, 1, 0, 5, 0};
    tbl[10] = '{1,  5, 0,  0, 1,   1, 1, 0, 5, 1};
    tbl[11] = '{0,  5, 0,  0, 1,   1, 1, 0, 5, 0};
    tbl[12] = '{0, 13, 0,  0, 0,   0, 0, 8, 5, 0};
    tbl[13] = '{1, 13, 0,  0, 0,   0, 0, 7, 6, 0};
    tbl[14] = '{0, 13, 1,  6, 0,   0, 0, 7, 6, 0};
    tbl[15] = '{1, 13, 0,  0, 0,   0, 1, 6, 7, 0};
    tbl[16] = '{0, 13, 1, 15, 0,   0, 1, 6, 7, 0};
    tbl[17] = '{0, 13, 0,  0, 0,   0, 1, 6, 7, 0};
    tbl[18] = '{1, 14, 0,  0, 0,   0, 1, 6, 8, 0};
    tbl[19] = '{0, 14, 1,  0, 0,   0, 1, 6, 8, 0};
    tbl[20] = '{0, 14, 0,  0, 0,   0, 0, 6, 8, 0};

    rrst_n = 0; rinc = 0; rq2_wptr = 0; ae_thresh_we = 0; ae_thresh = 0; rclr_err = 0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    chk("reset.rempty", rempty, 1);
    chk("reset.raempty", raempty, 1);
    chk("reset.rlevel", rlevel, 0);
    chk("reset.rd_ptr", rd_ptr, 0);
    chk("reset.raddr", raddr, 0);
    chk("reset.runderflow", runderflow, 0);
    rrst_n = 1;

    // Directed vectors: fill/drain, underflow, full occupancy, threshold.
    for (int i = 0; i < 21; i++) begin
      rinc = tbl[i].rinc; w = tbl[i].w; ae_thresh_we = tbl[i].twe;
      ae_thresh = 4'(tbl[i].thr); rclr_err = tbl[i].clr;
      step();
      chk($sformatf("vec%0d.rempty", i),     rempty,     tbl[i].e_empty);
      chk($sformatf("vec%0d.raempty", i),    raempty,    tbl[i].e_ae);
      chk($sformatf("vec%0d.rlevel", i),     rlevel,     tbl[i].e_lvl);
      chk($sformatf("vec%0d.raddr", i),      raddr,      tbl[i].e_rd % DEPTH);
      chk($sformatf("vec%0d.rd_ptr", i),     rd_ptr,     gray4(tbl[i].e_rd));
      chk($sformatf("vec%0d.runderflow", i), runderflow, tbl[i].e_uf);
      $display("vec%0d rinc=%0b w=%0d -> rempty=%0b raempty=%0b rlevel=%0d raddr=%0d uf=%0b",
               i, rinc, w, rempty, raempty, rlevel, raddr, runderflow);
    end

    // Wrap: 20 simultaneous write/pop pairs; pointer crosses 15->0.
    ae_thresh_we = 0; rclr_err = 0;
    for (int i = 0; i < 20; i++) begin
      prev_ptr = rd_ptr;
      rinc = 1; w = w + 1;
      step();
      chk($sformatf("wrap%0d.gray_step", i), $countones(rd_ptr ^ prev_ptr), 1);
      chk($sformatf("wrap%0d.rlevel", i), rlevel, 6);
      chk($sformatf("wrap%0d.rempty", i), rempty, 0);
      chk_model($sformatf("wrap%0d", i));
      $display("wrap%0d rd_ptr=%b rlevel=%0d", i, rd_ptr, rlevel);
    end

    // Reset in the middle of traffic: outputs clear before the next edge.
    rinc = 1;
    #2 rrst_n = 0;
    #1;
    chk("midrst.rempty", rempty, 1);
    chk("midrst.raempty", raempty, 1);
    chk("midrst.rlevel", rlevel, 0);
    chk("midrst.rd_ptr", rd_ptr, 0);
    chk("midrst.raddr", raddr, 0);
    chk("midrst.runderflow", runderflow, 0);
    @(posedge rclk); #1;
    chk("midrst_hold.rd_ptr", rd_ptr, 0);
    $display("midrst rempty=%0b rlevel=%0d rd_ptr=%b", rempty, rlevel, rd_ptr);
    rinc = 0; w = 0; rq2_wptr = 0;
    model_reset();
    rrst_n = 1;

    // Randomised traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      if ((w - m_rd) < DEPTH && $urandom_range(0, 1) == 1) w = w + 1;
      rinc         = ($urandom_range(0, 2) != 0);
      ae_thresh_we = ($urandom_range(0, 9) == 0);
      ae_thresh    = 4'($urandom_range(0, 15));
      rclr_err     = ($urandom_range(0, 7) == 0);
      step();
      chk_model($sformatf("rnd%0d", i));
      $display("rnd%0d rinc=%0b w=%0d -> rempty=%0b raempty=%0b rlevel=%0d uf=%0b",
               i, rinc, w, rempty, raempty, rlevel, runderflow);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
